irda_fir_4ppm_decoder: RTL
==========================

Name: irda_fir_4ppm_decoder

Overview:
- Consumes the chip stream from the FIR (4 Mbps, 4PPM) bit synchronizer and decodes it into bytes.
- Hunts for the 32-chip start flag, then decodes 4-chip symbols into data bit pairs and assembles LSB-first bytes.
- Verifies the stop flag, then pulses restart back to the bit synchronizer.
- Output feeds the FIR CRC-32 checker and receive FIFO.

Parameters:
- MAX_FRAME_BYTES, 2050, maximum bytes between start and stop flags; exceeding it is an overrun error.
- BCNT_W, 12, width of the byte counter; must satisfy 2^BCNT_W > MAX_FRAME_BYTES.

Ports:
- clk  in  1  system clock.
- wb_rst_n_i  in  1  reset, asynchronous, active-low.
- restart  in  1  synchronous abort: return to HUNT.
- bs_i  in  1  chip value from the bit synchronizer.
- bs_valid  in  1  one-clk strobe per chip; bs_i is valid when bs_valid is high.
- rx_data  out  8  decoded byte.
- rx_valid  out  1  one-clk pulse, rx_data valid.
- rx_sof  out  1  one-clk pulse, start flag detected.
- rx_eof  out  1  one-clk pulse, valid stop flag received.
- rx_err  out  1  one-clk pulse, frame aborted.
- rx_err_code  out  2  reason code, held until the next rx_err or rx_sof.
- byte_cnt  out  BCNT_W  bytes delivered in the current frame.
- bs_restart_o  out  1  one-clk pulse to the bit synchronizer's bs_restart input.

Behaviour:
- Reset (wb_rst_n_i low, async): state=HUNT, window=0, all pulses 0, rx_data=0, rx_err_code=0, byte_cnt=0.
- All sequential activity is gated by bs_valid, except reset and restart.
- restart has priority over a simultaneous bs_valid. It forces HUNT, clears window, sym_idx and chip_idx, and generates no pulses.
- window[31:0] shifts left on each bs_valid, with bs_i entering bit 0. The earliest chip ends up at bit 31.
- Flags, chip-transmit order MSB first:
  - START_FLAG = 32'h0C0C_6006
  - STOP_FLAG = 32'h0C0C_0606
- Symbol decode, nibble {c0,c1,c2,c3} in arrival order:
  - 1000 -> 2'b00
  - 0100 -> 2'b01
  - 0010 -> 2'b10
  - 0001 -> 2'b11
  - any other nibble is illegal.
- States:
  - HUNT: after each shift, if the new window equals START_FLAG: rx_sof pulses next clk, byte_cnt=0, chip_idx=0, sym_idx=0, go to DATA. Preamble and noise are ignored. Detection works at any chip alignment.
  - DATA: chip_idx counts 0..3. At chip 3, decode window[3:0].
    - Legal symbol: dibit is placed at byte bits [2*sym_idx+1 : 2*sym_idx], sym_idx increments.
    - Byte completes at sym_idx=3: if byte_cnt == MAX_FRAME_BYTES, rx_err with code 2'b11, go to ABORT. Otherwise rx_data updates, rx_valid pulses and byte_cnt increments, all one clk after the strobe.
    - Illegal symbol with sym_idx==0: go to STOPCHK, stop_cnt=4.
    - Illegal symbol with sym_idx!=0: rx_err with code 2'b01, go to ABORT.
  - STOPCHK: stop_cnt counts chips to 32. At 32, if window==STOP_FLAG, rx_eof pulses; otherwise rx_err with code 2'b10. Then go to ABORT.
  - ABORT: single-clk state. Drives bs_restart_o=1, clears window, returns to HUNT. rx_eof and rx_err are asserted in the same clk as bs_restart_o.
- Latency: strobe of the last chip -> rx_valid / rx_sof / rx_eof / rx_err is exactly 1 clk.
- An empty frame (start flag followed immediately by stop flag) is legal: rx_eof with byte_cnt=0.
- byte_cnt holds its value after eof/err until the next rx_sof.

Decomposition:
- Package irda_fir_pkg holds:
  - START_FLAG and STOP_FLAG constants
  - state enum {HUNT, DATA, STOPCHK, ABORT}
  - error-code constants: ERR_SYM=2'b01, ERR_STOP=2'b10, ERR_OVR=2'b11
- One sub-module, irda_fir_4ppm_sym_dec: combinational 4-chip -> {legal, dibit[1:0]}.

Test Plan:
- 16 preamble repetitions, START_FLAG, symbols for byte 8'hA5 (dibits 01,01,10,10 -> chips 0100 0100 0010 0010), then STOP_FLAG -> rx_sof once; rx_valid with rx_data=8'hA5; rx_eof; byte_cnt=1; bs_restart_o pulses with rx_eof.
- START_FLAG immediately followed by STOP_FLAG -> rx_sof then rx_eof; byte_cnt=0; no rx_valid.
- START_FLAG, one legal symbol, then chips 1100 -> rx_err, rx_err_code=2'b01, bs_restart_o pulses; later START_FLAG -> rx_sof again.
- START_FLAG, byte 8'h00, then 32 chips 0000_1100_0000_1100_0000_0110_0000_0111 -> rx_err, rx_err_code=2'b10, no rx_eof.
- MAX_FRAME_BYTES=4, send 5 bytes 8'hFF -> four rx_valid, then rx_err with rx_err_code=2'b11; byte_cnt=4.
- restart asserted in the same clk as bs_valid mid-frame, and wb_rst_n_i low mid-byte -> HUNT, no pulses, all outputs at reset values; the next START_FLAG is detected normally.

Source files
------------

// File: rtl/irda_fir_pkg.sv
// Shared constants and types for the FIR 4PPM receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package irda_fir_pkg;

  // Flags as seen in the chip window: earliest chip at bit 31.
  localparam logic [31:0] START_FLAG = 32'h0C0C_6006;
  localparam logic [31:0] STOP_FLAG  = 32'h0C0C_0606;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    DATA    = 2'd1,
    STOPCHK = 2'd2,
    ABORT   = 2'd3
  } state_e;

  localparam logic [1:0] ERR_SYM  = 2'b01;
  localparam logic [1:0] ERR_STOP = 2'b10;
  localparam logic [1:0] ERR_OVR  = 2'b11;

endpackage

// File: rtl/irda_fir_4ppm_sym_dec.sv
// 4PPM symbol decoder: one 4-chip nibble -> {legal, dibit}.
// Latency: combinational.
// Backpressure: none.
// Ports: i_chips {c0,c1,c2,c3} (c0 earliest, at bit 3); o_legal; o_dibit.
module irda_fir_4ppm_sym_dec (
  input  logic [3:0] i_chips,
  output logic       o_legal,
  output logic [1:0] o_dibit
);

  always_comb begin
    o_legal = 1'b1;
    o_dibit = 2'b00;
    case (i_chips)
      4'b1000: o_dibit = 2'b00;
      4'b0100: o_dibit = 2'b01;
      4'b0010: o_dibit = 2'b10;
      4'b0001: o_dibit = 2'b11;
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/irda_fir_4ppm_decoder.sv
// FIR 4PPM frame decoder: hunts start flag, decodes symbols into LSB-first bytes, checks stop flag.
// Latency: 1 clk from the strobe of the last chip to rx_valid/rx_sof/rx_eof/rx_err.
// Backpressure: none; consumes one chip per bs_valid strobe, outputs are one-clk pulses.
// Ports: clk, wb_rst_n_i (async low), restart (sync abort), bs_i/bs_valid chip input,
//        rx_data/rx_valid/rx_sof/rx_eof/rx_err/rx_err_code/byte_cnt to CRC/FIFO, bs_restart_o to bit sync.
module irda_fir_4ppm_decoder
  import irda_fir_pkg::*;
#(
  parameter int MAX_FRAME_BYTES = 2050,
  parameter int BCNT_W          = 12
) (
  input  logic              clk,
  input  logic              wb_rst_n_i,
  input  logic              restart,
  input  logic              bs_i,
  input  logic              bs_valid,
  output logic [7:0]        rx_data,
  output logic              rx_valid,
  output logic              rx_sof,
  output logic              rx_eof,
  output logic              rx_err,
  output logic [1:0]        rx_err_code,
  output logic [BCNT_W-1:0] byte_cnt,
  output logic              bs_restart_o
);

  localparam logic [BCNT_W-1:0] MAX_CNT = BCNT_W'(MAX_FRAME_BYTES);

  state_e      r_state;
  logic [31:0] r_window;
  logic [1:0]  r_chip_idx;
  logic [1:0]  r_sym_idx;
  logic [5:0]  r_part;      // dibits 0..2 of the byte being assembled
  logic [5:0]  r_stop_cnt;

  logic [31:0] w_win_next;
  logic        w_legal;
  logic [1:0]  w_dibit;

  assign w_win_next = {r_window[30:0], bs_i};

  // Decode the nibble that includes the chip arriving this strobe.
  irda_fir_4ppm_sym_dec u_sym_dec (
    .i_chips (w_win_next[3:0]),
    .o_legal (w_legal),
    .o_dibit (w_dibit)
  );

  always_ff @(posedge clk or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state      <= HUNT;
      r_window     <= '0;
      r_chip_idx   <= '0;
      r_sym_idx    <= '0;
      r_part       <= '0;
      r_stop_cnt   <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_sof       <= 1'b0;
      rx_eof       <= 1'b0;
      rx_err       <= 1'b0;
      rx_err_code  <= '0;
      byte_cnt     <= '0;
      bs_restart_o <= 1'b0;
    end else begin
      rx_valid     <= 1'b0;
      rx_sof       <= 1'b0;
      rx_eof       <= 1'b0;
      rx_err       <= 1'b0;
      bs_restart_o <= 1'b0;
      if (restart) begin
        r_state    <= HUNT;
        r_window   <= '0;
        r_chip_idx <= '0;
        r_sym_idx  <= '0;
      end else if (r_state == ABORT) begin
        // Single-clk state; the eof/err and bs_restart_o pulses are visible now.
        r_window <= '0;
        r_state  <= HUNT;
      end else if (bs_valid) begin
        r_window <= w_win_next;
        case (r_state)
          HUNT: begin
            if (w_win_next == START_FLAG) begin
              rx_sof      <= 1'b1;
              rx_err_code <= '0;
              byte_cnt    <= '0;
              r_chip_idx  <= '0;
              r_sym_idx   <= '0;
              r_state     <= DATA;
            end
          end
          DATA: begin
            r_chip_idx <= r_chip_idx + 2'd1;
            if (r_chip_idx == 2'd3) begin
              if (w_legal) begin
                if (r_sym_idx == 2'd3) begin
                  r_sym_idx <= '0;
                  if (byte_cnt == MAX_CNT) begin
                    rx_err       <= 1'b1;
                    rx_err_code  <= ERR_OVR;
                    bs_restart_o <= 1'b1;
                    r_state      <= ABORT;
                  end else begin
                    rx_data  <= {w_dibit, r_part};
                    rx_valid <= 1'b1;
                    byte_cnt <= byte_cnt + BCNT_W'(1);
                  end
                end else begin
                  r_part[{r_sym_idx, 1'b0} +: 2] <= w_dibit;
                  r_sym_idx <= r_sym_idx + 2'd1;
                end
              end else if (r_sym_idx == 2'd0) begin
                // Illegal nibble on a byte boundary: candidate stop flag, 4 chips already in.
                r_stop_cnt <= 6'd4;
                r_state    <= STOPCHK;
              end else begin
                rx_err       <= 1'b1;
                rx_err_code  <= ERR_SYM;
                bs_restart_o <= 1'b1;
                r_state      <= ABORT;
              end
            end
          end
          STOPCHK: begin
            r_stop_cnt <= r_stop_cnt + 6'd1;
            if (r_stop_cnt == 6'd31) begin
              if (w_win_next == STOP_FLAG) begin
                rx_eof <= 1'b1;
              end else begin
                rx_err      <= 1'b1;
                rx_err_code <= ERR_STOP;
              end
              bs_restart_o <= 1'b1;
              r_state      <= ABORT;
            end
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

endmodule
